// File: rtl/lstm_ctrl_pkg.sv
// rtl/lstm_ctrl_pkg.sv - state codes and sizing helpers shared by the LSTM sequencer
package lstm_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int ST_W   = 4;

  typedef logic [ST_W-1:0] state_t;

  localparam logic [ST_W-1:0] S_IDLE   = 4'd0;
  localparam logic [ST_W-1:0] S_ACC1   = 4'd1;
  localparam logic [ST_W-1:0] S_DRAIN1 = 4'd2;
  localparam logic [ST_W-1:0] S_WR1    = 4'd3;
  localparam logic [ST_W-1:0] S_CLR1   = 4'd4;
  localparam logic [ST_W-1:0] S_ACC2   = 4'd5;
  localparam logic [ST_W-1:0] S_DRAIN2 = 4'd6;
  localparam logic [ST_W-1:0] S_WR2    = 4'd7;
  localparam logic [ST_W-1:0] S_CLR2   = 4'd8;
  localparam logic [ST_W-1:0] S_DONE   = 4'd9;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cycles from the first ACC1 cycle up to (not including) DONE.
  function automatic int cycles_per_run(input int ts, input int n_in, input int c1, input int c2);
    return ts * (c1 * (max_int(n_in, c1) + 3) + c2 * (max_int(c1, c2) + 3));
  endfunction

endpackage

// File: rtl/lstm_layer_seq.sv
// rtl/lstm_layer_seq.sv - per-layer k counter plus accumulate enables and read addresses
module lstm_layer_seq
  import lstm_ctrl_pkg::*;
#(
  parameter int N_IN   = 53,
  parameter int N_CELL = 53,
  parameter int ADDR   = ADDR_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            clr_i,
  input  logic [ADDR-1:0] t_i,
  input  logic [ADDR-1:0] j_i,
  output logic            acc_x_o,
  output logic            acc_h_o,
  output logic            k_last_o,
  output logic [ADDR-1:0] rd_addr_x_o,
  output logic [ADDR-1:0] rd_addr_w_o,
  output logic [ADDR-1:0] rd_addr_u_o,
  output logic [ADDR-1:0] rd_addr_h_o,
  output logic [ADDR-1:0] rd_addr_b_o
);

  localparam int              K     = max_int(N_IN, N_CELL);
  localparam logic [ADDR-1:0] NIN   = ADDR'(N_IN);
  localparam logic [ADDR-1:0] NCELL = ADDR'(N_CELL);
  localparam logic [ADDR-1:0] KL    = ADDR'(K - 1);

  logic [ADDR-1:0] k_q, k_d;
  logic [ADDR-1:0] kx, ku;

  assign k_last_o = (k_q == KL);

  // k parks on its last value after ACC so addresses stay clamped through drain/write.
  always_comb begin
    k_d = k_q;
    if (clr_i) begin
      k_d = '0;
    end else if (run_i && !k_last_o) begin
      k_d = k_q + ADDR'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign kx = (k_q < NIN)   ? k_q : NIN - ADDR'(1);
  assign ku = (k_q < NCELL) ? k_q : NCELL - ADDR'(1);

  assign acc_x_o = run_i && (k_q < NIN);
  assign acc_h_o = run_i && (k_q < NCELL) && (t_i != '0);

  assign rd_addr_x_o = t_i * NIN + kx;
  assign rd_addr_w_o = j_i * NIN + kx;
  assign rd_addr_u_o = j_i * NCELL + ku;
  // No previous timestep exists at t=0, so the h address rests at zero there.
  assign rd_addr_h_o = (t_i == '0) ? '0 : (t_i - ADDR'(1)) * NCELL + ku;
  assign rd_addr_b_o = j_i;

endmodule

// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - two-layer LSTM sequencing FSM: owns t, j and state, drives strobes/addresses
module lstm_seq_ctrl
  import lstm_ctrl_pkg::*;
#(
  parameter int TIMESTEP    = 7,
  parameter int LAYR1_INPUT = 53,
  parameter int LAYR1_CELL  = 53,
  parameter int LAYR2_CELL  = 8,
  parameter int ADDR        = ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            clr_1,
  output logic            clr_2,
  output logic            acc_x_1,
  output logic            acc_h_1,
  output logic            acc_x_2,
  output logic            acc_h_2,
  output logic            wr_h1,
  output logic            wr_c1,
  output logic            wr_h2,
  output logic            wr_c2,
  output logic [ADDR-1:0] addr_x1,
  output logic [ADDR-1:0] rd_addr_w_1,
  output logic [ADDR-1:0] rd_addr_u_1,
  output logic [ADDR-1:0] rd_addr_b_1,
  output logic [ADDR-1:0] rd_addr_h1,
  output logic [ADDR-1:0] wr_addr_h1,
  output logic [ADDR-1:0] wr_addr_c1,
  output logic [ADDR-1:0] rd_addr_x2,
  output logic [ADDR-1:0] rd_addr_w_2,
  output logic [ADDR-1:0] rd_addr_u_2,
  output logic [ADDR-1:0] rd_addr_b_2,
  output logic [ADDR-1:0] rd_addr_h2,
  output logic [ADDR-1:0] wr_addr_h2,
  output logic [ADDR-1:0] wr_addr_c2
);

  if (longint'(TIMESTEP) * longint'(LAYR1_INPUT) > (longint'(1) << ADDR)) begin : g_addr_check
    $error("lstm_seq_ctrl: TIMESTEP*LAYR1_INPUT does not fit in ADDR bits");
  end

  localparam logic [ADDR-1:0] C1      = ADDR'(LAYR1_CELL);
  localparam logic [ADDR-1:0] C2      = ADDR'(LAYR2_CELL);
  localparam logic [ADDR-1:0] C1_LAST = ADDR'(LAYR1_CELL - 1);
  localparam logic [ADDR-1:0] C2_LAST = ADDR'(LAYR2_CELL - 1);
  localparam logic [ADDR-1:0] TS_LAST = ADDR'(TIMESTEP - 1);

  state_t          state_q, state_d;
  logic [ADDR-1:0] t_q, t_d;
  logic [ADDR-1:0] j_q, j_d;
  logic            k_last1, k_last2;
  logic            run1, run2;

  assign run1 = (state_q == S_ACC1);
  assign run2 = (state_q == S_ACC2);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACC1;
          t_d     = '0;
          j_d     = '0;
        end
      end
      S_ACC1:   if (k_last1) state_d = S_DRAIN1;
      S_DRAIN1: state_d = S_WR1;
      S_WR1:    state_d = S_CLR1;
      S_CLR1: begin
        if (j_q < C1_LAST) begin
          j_d     = j_q + ADDR'(1);
          state_d = S_ACC1;
        end else begin
          j_d     = '0;
          state_d = S_ACC2;
        end
      end
      S_ACC2:   if (k_last2) state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_WR2;
      S_WR2:    state_d = S_CLR2;
      S_CLR2: begin
        if (j_q < C2_LAST) begin
          j_d     = j_q + ADDR'(1);
          state_d = S_ACC2;
        end else if (t_q < TS_LAST) begin
          t_d     = t_q + ADDR'(1);
          j_d     = '0;
          state_d = S_ACC1;
        end else begin
          j_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Zero the counters so IDLE presents the same address pattern as reset.
        state_d = S_IDLE;
        t_d     = '0;
        j_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      j_q     <= j_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign clr_1 = (state_q == S_IDLE) || (state_q == S_CLR1) || (state_q == S_DONE);
  assign clr_2 = (state_q == S_IDLE) || (state_q == S_CLR2) || (state_q == S_DONE);

  assign wr_h1 = (state_q == S_WR1);
  assign wr_c1 = (state_q == S_WR1);
  assign wr_h2 = (state_q == S_WR2);
  assign wr_c2 = (state_q == S_WR2);

  assign wr_addr_h1 = t_q * C1 + j_q;
  assign wr_addr_c1 = t_q * C1 + j_q;
  assign wr_addr_h2 = t_q * C2 + j_q;
  assign wr_addr_c2 = t_q * C2 + j_q;

  lstm_layer_seq #(
    .N_IN  (LAYR1_INPUT),
    .N_CELL(LAYR1_CELL),
    .ADDR  (ADDR)
  ) u_layer1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .run_i      (run1),
    .clr_i      (clr_1),
    .t_i        (t_q),
    .j_i        (j_q),
    .acc_x_o    (acc_x_1),
    .acc_h_o    (acc_h_1),
    .k_last_o   (k_last1),
    .rd_addr_x_o(addr_x1),
    .rd_addr_w_o(rd_addr_w_1),
    .rd_addr_u_o(rd_addr_u_1),
    .rd_addr_h_o(rd_addr_h1),
    .rd_addr_b_o(rd_addr_b_1)
  );

  lstm_layer_seq #(
    .N_IN  (LAYR1_CELL),
    .N_CELL(LAYR2_CELL),
    .ADDR  (ADDR)
  ) u_layer2 (
    .clk_i      (clk),
    .rst_i      (rst),
    .run_i      (run2),
    .clr_i      (clr_2),
    .t_i        (t_q),
    .j_i        (j_q),
    .acc_x_o    (acc_x_2),
    .acc_h_o    (acc_h_2),
    .k_last_o   (k_last2),
    .rd_addr_x_o(rd_addr_x2),
    .rd_addr_w_o(rd_addr_w_2),
    .rd_addr_u_o(rd_addr_u_2),
    .rd_addr_h_o(rd_addr_h2),
    .rd_addr_b_o(rd_addr_b_2)
  );

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - self-checking bench: small-config trace model, vector table, default-size run
module tb_lstm_seq_ctrl;
  import lstm_ctrl_pkg::*;

  localparam int S_TS = 2, S_IN = 3, S_C1 = 2, S_C2 = 1;
  localparam int S_K1 = (S_IN > S_C1) ? S_IN : S_C1;
  localparam int S_K2 = (S_C1 > S_C2) ? S_C1 : S_C2;

  typedef struct packed {
    logic busy, done, clr_1, clr_2, acc_x_1, acc_h_1, acc_x_2, acc_h_2, wr_h1, wr_c1, wr_h2, wr_c2;
    logic [11:0] ax1, w1, u1, b1, h1, wah1, wac1, x2, w2, u2, b2, h2, wah2, wac2;
  } obs_t;

  localparam obs_t FLAG_MASK = obs_t'({12'hfff, 168'd0});
  localparam obs_t IDLE_OBS  = obs_t'({12'b0011_0000_0000, 168'd0});

  localparam int F_BUSY = 0, F_DONE = 1, F_CLR1 = 2, F_CLR2 = 3, F_AX1 = 4, F_AH1 = 5, F_AH2 = 6;
  localparam int F_WH1 = 7, F_WC1 = 8, F_WH2 = 9, F_A_X1 = 10, F_A_W1 = 11, F_A_U1 = 12;
  localparam int F_A_H1 = 13, F_A_WH1 = 14, F_A_X2 = 15, F_A_WH2 = 16;

  typedef struct {
    string name;
    int    off;
    int    sel;
    int    exp;
  } vec_t;

  logic clk = 0;
  always #5 clk = ~clk;

  logic s_rst, s_start, d_rst, d_start;
  logic s_busy, s_done, s_clr_1, s_clr_2, s_ax1e, s_ah1e, s_ax2e, s_ah2e, s_wh1, s_wc1, s_wh2, s_wc2;
  logic [11:0] s_ax1, s_w1, s_u1, s_b1, s_h1, s_wah1, s_wac1, s_x2, s_w2, s_u2, s_b2, s_h2, s_wah2, s_wac2;
  logic d_busy, d_done, d_clr_1, d_clr_2, d_ax1e, d_ah1e, d_ax2e, d_ah2e, d_wh1, d_wc1, d_wh2, d_wc2;
  logic [11:0] d_ax1, d_w1, d_u1, d_b1, d_h1, d_wah1, d_wac1, d_x2, d_w2, d_u2, d_b2, d_h2, d_wah2, d_wac2;
  obs_t s_obs, d_obs;

  assign s_obs = {s_busy, s_done, s_clr_1, s_clr_2, s_ax1e, s_ah1e, s_ax2e, s_ah2e, s_wh1, s_wc1, s_wh2, s_wc2,
                  s_ax1, s_w1, s_u1, s_b1, s_h1, s_wah1, s_wac1, s_x2, s_w2, s_u2, s_b2, s_h2, s_wah2, s_wac2};
  assign d_obs = {d_busy, d_done, d_clr_1, d_clr_2, d_ax1e, d_ah1e, d_ax2e, d_ah2e, d_wh1, d_wc1, d_wh2, d_wc2,
                  d_ax1, d_w1, d_u1, d_b1, d_h1, d_wah1, d_wac1, d_x2, d_w2, d_u2, d_b2, d_h2, d_wah2, d_wac2};

  lstm_seq_ctrl #(.TIMESTEP(S_TS), .LAYR1_INPUT(S_IN), .LAYR1_CELL(S_C1), .LAYR2_CELL(S_C2), .ADDR(12)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done), .clr_1(s_clr_1), .clr_2(s_clr_2),
    .acc_x_1(s_ax1e), .acc_h_1(s_ah1e), .acc_x_2(s_ax2e), .acc_h_2(s_ah2e),
    .wr_h1(s_wh1), .wr_c1(s_wc1), .wr_h2(s_wh2), .wr_c2(s_wc2),
    .addr_x1(s_ax1), .rd_addr_w_1(s_w1), .rd_addr_u_1(s_u1), .rd_addr_b_1(s_b1), .rd_addr_h1(s_h1),
    .wr_addr_h1(s_wah1), .wr_addr_c1(s_wac1),
    .rd_addr_x2(s_x2), .rd_addr_w_2(s_w2), .rd_addr_u_2(s_u2), .rd_addr_b_2(s_b2), .rd_addr_h2(s_h2),
    .wr_addr_h2(s_wah2), .wr_addr_c2(s_wac2));

  lstm_seq_ctrl #(.TIMESTEP(7), .LAYR1_INPUT(53), .LAYR1_CELL(53), .LAYR2_CELL(8), .ADDR(12)) u_dflt (
    .clk(clk), .rst(d_rst), .start(d_start), .busy(d_busy), .done(d_done), .clr_1(d_clr_1), .clr_2(d_clr_2),
    .acc_x_1(d_ax1e), .acc_h_1(d_ah1e), .acc_x_2(d_ax2e), .acc_h_2(d_ah2e),
    .wr_h1(d_wh1), .wr_c1(d_wc1), .wr_h2(d_wh2), .wr_c2(d_wc2),
    .addr_x1(d_ax1), .rd_addr_w_1(d_w1), .rd_addr_u_1(d_u1), .rd_addr_b_1(d_b1), .rd_addr_h1(d_h1),
    .wr_addr_h1(d_wah1), .wr_addr_c1(d_wac1),
    .rd_addr_x2(d_x2), .rd_addr_w_2(d_w2), .rd_addr_u_2(d_u2), .rd_addr_b_2(d_b2), .rd_addr_h2(d_h2),
    .wr_addr_h2(d_wah2), .wr_addr_c2(d_wac2));

  int   tests = 0;
  int   failures = 0;
  obs_t exp_q[$];
  obs_t msk_q[$];
  obs_t cap[64];
  vec_t vt[$];

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void push(input obs_t e, input obs_t m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endfunction

  // Expected per-cycle trace of one small-config run, from first ACC1 through DONE.
  function automatic void build_model();
    obs_t e, m;
    exp_q.delete();
    msk_q.delete();
    for (int t = 0; t < S_TS; t++) begin
      for (int j = 0; j < S_C1; j++) begin
        for (int k = 0; k < S_K1; k++) begin
          e = '0; m = FLAG_MASK; e.busy = 1;
          e.acc_x_1 = (k < S_IN);
          e.acc_h_1 = (k < S_C1) && (t != 0);
          e.ax1 = 12'(t * S_IN + mn(k, S_IN - 1));   m.ax1 = '1;
          e.w1  = 12'(j * S_IN + mn(k, S_IN - 1));   m.w1  = '1;
          e.u1  = 12'(j * S_C1 + mn(k, S_C1 - 1));   m.u1  = '1;
          e.b1  = 12'(j);                            m.b1  = '1;
          if (t != 0) begin
            e.h1 = 12'((t - 1) * S_C1 + mn(k, S_C1 - 1)); m.h1 = '1;
          end
          push(e, m);
        end
        e = '0; m = FLAG_MASK; e.busy = 1; e.b1 = 12'(j); m.b1 = '1;
        push(e, m);
        e.wr_h1 = 1; e.wr_c1 = 1;
        e.wah1 = 12'(t * S_C1 + j); e.wac1 = e.wah1; m.wah1 = '1; m.wac1 = '1;
        push(e, m);
        e = '0; m = FLAG_MASK; e.busy = 1; e.clr_1 = 1;
        push(e, m);
      end
      for (int j = 0; j < S_C2; j++) begin
        for (int k = 0; k < S_K2; k++) begin
          e = '0; m = FLAG_MASK; e.busy = 1;
          e.acc_x_2 = (k < S_C1);
          e.acc_h_2 = (k < S_C2) && (t != 0);
          e.x2 = 12'(t * S_C1 + mn(k, S_C1 - 1));    m.x2 = '1;
          e.w2 = 12'(j * S_C1 + mn(k, S_C1 - 1));    m.w2 = '1;
          e.u2 = 12'(j * S_C2 + mn(k, S_C2 - 1));    m.u2 = '1;
          e.b2 = 12'(j);                             m.b2 = '1;
          if (t != 0) begin
            e.h2 = 12'((t - 1) * S_C2 + mn(k, S_C2 - 1)); m.h2 = '1;
          end
          push(e, m);
        end
        e = '0; m = FLAG_MASK; e.busy = 1; e.b2 = 12'(j); m.b2 = '1;
        push(e, m);
        e.wr_h2 = 1; e.wr_c2 = 1;
        e.wah2 = 12'(t * S_C2 + j); e.wac2 = e.wah2; m.wah2 = '1; m.wac2 = '1;
        push(e, m);
        e = '0; m = FLAG_MASK; e.busy = 1; e.clr_2 = 1;
        push(e, m);
      end
    end
    e = '0; e.busy = 1; e.done = 1; e.clr_1 = 1; e.clr_2 = 1;
    push(e, FLAG_MASK);
  endfunction

  function automatic int fld(input obs_t o, input int sel);
    case (sel)
      F_BUSY:  return int'(o.busy);
      F_DONE:  return int'(o.done);
      F_CLR1:  return int'(o.clr_1);
      F_CLR2:  return int'(o.clr_2);
      F_AX1:   return int'(o.acc_x_1);
      F_AH1:   return int'(o.acc_h_1);
      F_AH2:   return int'(o.acc_h_2);
      F_WH1:   return int'(o.wr_h1);
      F_WC1:   return int'(o.wr_c1);
      F_WH2:   return int'(o.wr_h2);
      F_A_X1:  return int'(o.ax1);
      F_A_W1:  return int'(o.w1);
      F_A_U1:  return int'(o.u1);
      F_A_H1:  return int'(o.h1);
      F_A_WH1: return int'(o.wah1);
      F_A_X2:  return int'(o.x2);
      F_A_WH2: return int'(o.wah2);
      default: return -1;
    endcase
  endfunction

  function automatic void addv(input string n, input int off, input int sel, input int exp);
    vec_t v;
    v.name = n; v.off = off; v.sel = sel; v.exp = exp;
    vt.push_back(v);
  endfunction

  task automatic cmp_obs(input string nm, input obs_t got, input obs_t exp, input obs_t m);
    tests++;
    if (((got ^ exp) & m) != '0) begin
      failures++;
      $display("FAIL %s: got %h want %h (mask %h)", nm, got & m, exp & m, m);
    end
  endtask

  task automatic cmp_int(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // Entered at a negedge with the small DUT idle; leaves it idle at a negedge.
  task automatic run_small(input int id, input bit spurious, input bit capture);
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      cmp_obs($sformatf("run%0d_cyc%0d", id, i), s_obs, exp_q[i], msk_q[i]);
      if (capture) cap[i] = s_obs;
      s_start = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
    end
    s_start = 0;
    if (capture) cap[exp_q.size()] = s_obs;
    cmp_obs($sformatf("run%0d_after_done", id), s_obs, IDLE_OBS, FLAG_MASK);
  endtask

  initial begin
    int cnt, h1, h2;
    bit wr_seen;
    s_rst = 1; d_rst = 1; s_start = 0; d_start = 0;
    repeat (2) @(negedge clk);
    cmp_obs("reset_small", s_obs, IDLE_OBS, '1);
    cmp_obs("reset_dflt", d_obs, IDLE_OBS, '1);
    s_rst = 0; d_rst = 0;
    @(negedge clk);

    build_model();
    cmp_int("model_len_vs_pkg", exp_q.size(), cycles_per_run(S_TS, S_IN, S_C1, S_C2) + 1);
    run_small(0, 1'b0, 1'b1);

    addv("c0_accx_k0", 0, F_AX1, 1);  addv("c0_acch_k0", 0, F_AH1, 0);  addv("c0_ax1_k0", 0, F_A_X1, 0);
    addv("c0_accx_k1", 1, F_AX1, 1);  addv("c0_acch_k1", 1, F_AH1, 0);  addv("c0_ax1_k1", 1, F_A_X1, 1);
    addv("c0_accx_k2", 2, F_AX1, 1);  addv("c0_acch_k2", 2, F_AH1, 0);  addv("c0_ax1_k2", 2, F_A_X1, 2);
    addv("c0_drain_accx", 3, F_AX1, 0); addv("c0_drain_wr", 3, F_WH1, 0);
    addv("c0_wr_h", 4, F_WH1, 1);     addv("c0_wr_c", 4, F_WC1, 1);    addv("c0_wr_addr", 4, F_A_WH1, 0);
    addv("c0_wr_noclr", 4, F_CLR1, 0); addv("c0_clr1", 5, F_CLR1, 1);   addv("c0_clr_nowr", 5, F_WH1, 0);
    addv("t1c1_acch_k0", 23, F_AH1, 1); addv("t1c1_acch_k1", 24, F_AH1, 1); addv("t1c1_acch_k2", 25, F_AH1, 0);
    addv("t1c1_h_k0", 23, F_A_H1, 0);  addv("t1c1_h_k1", 24, F_A_H1, 1);  addv("t1c1_h_k2", 25, F_A_H1, 1);
    addv("t1c1_u_k0", 23, F_A_U1, 2);  addv("t1c1_u_k1", 24, F_A_U1, 3);  addv("t1c1_u_k2", 25, F_A_U1, 3);
    addv("t1c1_w_k0", 23, F_A_W1, 3);  addv("t1c1_w_k1", 24, F_A_W1, 4);  addv("t1c1_w_k2", 25, F_A_W1, 5);
    addv("t1c1_x_k0", 23, F_A_X1, 3);  addv("t1c1_x_k1", 24, F_A_X1, 4);  addv("t1c1_x_k2", 25, F_A_X1, 5);
    addv("t1c1_wr", 27, F_WH1, 1);     addv("t1c1_wr_addr", 27, F_A_WH1, 3);
    addv("l2_x_k0", 29, F_A_X2, 2);    addv("l2_x_k1", 30, F_A_X2, 3);
    addv("l2_acch_k0", 29, F_AH2, 1);  addv("l2_acch_k1", 30, F_AH2, 0);
    addv("l2_wr", 32, F_WH2, 1);       addv("l2_wr_addr", 32, F_A_WH2, 1); addv("l2_wr_no_l1", 32, F_WH1, 0);
    addv("l2_clr2", 33, F_CLR2, 1);    addv("l2_done_early", 33, F_DONE, 0);
    addv("done_pulse", 34, F_DONE, 1); addv("done_gone", 35, F_DONE, 0);   addv("idle_busy", 35, F_BUSY, 0);
    foreach (vt[i]) cmp_int(vt[i].name, fld(cap[vt[i].off], vt[i].sel), vt[i].exp);

    for (int r = 1; r <= 5; r++) begin
      repeat ($urandom_range(0, 4)) begin
        cmp_obs($sformatf("idle_gap%0d", r), s_obs, IDLE_OBS, FLAG_MASK);
        @(negedge clk);
      end
      run_small(r, 1'b1, 1'b0);
    end

    // Reset in the cycle before WR1 of t=1 cell 0.
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    repeat (20) @(negedge clk);
    cmp_int("pre_rst_busy", int'(s_busy), 1);
    s_rst = 1;
    #1;
    cmp_int("rst_busy", int'(s_busy), 0);
    cmp_int("rst_clr1", int'(s_clr_1), 1);
    @(negedge clk);
    s_rst = 0;
    wr_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_wh1 || s_busy) wr_seen = 1;
    end
    cmp_int("rst_no_write_or_busy", int'(wr_seen), 0);
    run_small(9, 1'b0, 1'b0);
    cmp_int("restart_ax1_first", int'(cap[0].ax1), 0);

    d_start = 1;
    @(negedge clk);
    d_start = 0;
    cnt = 0; h1 = 0; h2 = 0;
    cmp_int("dflt_first_busy", int'(d_busy), 1);
    while (!d_done && cnt < 30000) begin
      if (d_wh1) h1++;
      if (d_wh2) h2++;
      d_start = (cnt == 5000 || cnt == 12345 || cnt == 23000);
      @(negedge clk);
      cnt++;
    end
    d_start = 0;
    cmp_int("dflt_cycles_to_done", cnt, 23912);
    cmp_int("dflt_wr_h1_pulses", h1, 371);
    cmp_int("dflt_wr_h2_pulses", h2, 56);
    @(negedge clk);
    cmp_int("dflt_done_one_cycle", int'(d_done), 0);
    cmp_int("dflt_idle_after", int'(d_busy), 0);
    repeat (3) @(negedge clk);
    cmp_int("dflt_no_restart", int'(d_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
